// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

   typedef enum logic {IDLE, BUSY} arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
// Reusable by any controller that shares one resource among N requesters.
module rr_pick #(
   parameter int  N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] cand;

   // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      found = |req;
      idx   = '0;
      cand  = '0;
      // Scan from the farthest candidate back to last+1 so the nearest one wins.
      for (int i = N; i >= 1; i--) begin
         cand = IW'((int'(last) + i) % N);
         if (req[cand]) idx = cand;
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among NREQ
// producers; FIFO full stalls only the current owner.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic                    fifo_wr,
   output logic [WIDTH-1:0]        fifo_data_in,
   input  logic                    fifo_full,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

   arb_state_t     state;
   logic [IW-1:0]  owner;
   logic [IW-1:0]  last;
   logic [CW-1:0]  burst_cnt;
   logic           pick_found;
   logic [IW-1:0]  pick_idx;
   logic [WIDTH-1:0] words [NREQ];

   rr_pick #(.N(NREQ)) u_pick (
      .req   (req_valid),
      .last  (last),
      .found (pick_found),
      .idx   (pick_idx)
   );

   for (genvar g = 0; g < NREQ; g++) begin : g_words
      assign words[g] = req_data[g*WIDTH +: WIDTH];
   end

   assign busy         = (state == BUSY);
   assign grant_id     = owner;
   assign fifo_data_in = words[owner];
   assign fifo_wr      = busy && req_valid[owner] && !fifo_full;

   always_comb begin
      req_ready = '0;
      if (busy) req_ready[owner] = !fifo_full;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= '0;
         last      <= IW'(NREQ - 1);
         burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  owner     <= pick_idx;
                  burst_cnt <= '0;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               // A dropped valid releases the grant; full with valid just stalls.
               if (!req_valid[owner]) begin
                  last  <= owner;
                  state <= IDLE;
               end else if (!fifo_full) begin
                  if (burst_cnt == LAST_BEAT) begin
                     last  <= owner;
                     state <= IDLE;
                  end else begin
                     burst_cnt <= burst_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner
// sequences and a randomized run against a behavioural reference model.
module tb_fifo_wr_arbiter;

   localparam int NREQ      = 4;
   localparam int WIDTH     = 8;
   localparam int MAX_BURST = 4;
   localparam int IW        = 2;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  fifo_wr;
   logic [WIDTH-1:0]      fifo_data_in;
   logic                  fifo_full;
   logic [IW-1:0]         grant_id;
   logic                  busy;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_wr      (fifo_wr),
      .fifo_data_in (fifo_data_in),
      .fifo_full    (fifo_full),
      .grant_id     (grant_id),
      .busy         (busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: who holds the grant, who last released it, words sent.
   int m_busy, m_owner, m_last, m_done;
   int wlog[$];
   int clog[$];

   typedef struct {
      logic [3:0] valid;
      logic       full;
      logic       busy;
      logic [1:0] gid;
      logic       wr;
      logic [3:0] ready;
   } vec_t;
   vec_t tbl[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [WIDTH-1:0] word(input int i);
      return req_data[i*WIDTH +: WIDTH];
   endfunction

   task automatic set_words(input int base);
      for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'(base + i);
   endtask

   task automatic model_reset();
      m_busy  = 0;
      m_owner = 0;
      m_last  = NREQ - 1;
      m_done  = 0;
   endtask

   task automatic model_advance();
      bit found;
      if (reset) begin
         model_reset();
      end else if (m_busy == 0) begin
         found = 0;
         for (int k = 1; k <= NREQ; k++) begin
            int c = (m_last + k) % NREQ;
            if (!found && req_valid[c]) begin
               found   = 1;
               m_owner = c;
               m_busy  = 1;
               m_done  = 0;
            end
         end
      end else if (!req_valid[m_owner]) begin
         m_last = m_owner;
         m_busy = 0;
      end else if (!fifo_full) begin
         m_done++;
         if (m_done == MAX_BURST) begin
            m_last = m_owner;
            m_busy = 0;
         end
      end
   endtask

   task automatic sample();
      logic [NREQ-1:0] exp_ready;
      logic            exp_wr;
      @(negedge clk);
      exp_ready = (m_busy != 0 && !fifo_full) ? NREQ'(1 << m_owner) : '0;
      exp_wr    = (m_busy != 0) && req_valid[m_owner] && !fifo_full;
      check("model_busy", busy, m_busy);
      check("model_grant_id", grant_id, m_owner);
      check("model_req_ready", req_ready, exp_ready);
      check("model_fifo_wr", fifo_wr, exp_wr);
      if (m_busy != 0) check("model_fifo_data", fifo_data_in, word(m_owner));
      if (fifo_wr) wlog.push_back(int'(fifo_data_in));
      clog.push_back(fifo_wr ? int'(fifo_data_in) : -1);
   endtask

   task automatic advance();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic step();
      sample();
      advance();
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      model_reset();
      req_valid = NREQ'($urandom);
      fifo_full = 1'b0;
      step();
      check("rst_busy", busy, 1'b0);
      check("rst_fifo_wr", fifo_wr, 1'b0);
      check("rst_req_ready", req_ready, '0);
      step();
      reset     = 1'b0;
      req_valid = '0;
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      fifo_full = 1'b0;
      req_data  = '0;
      model_reset();

      // Vector table: first grant, back-pressure on P2, early release by P3, wrap to P0.
      tbl[0]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
      tbl[1]  = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001};
      tbl[2]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0001};
      tbl[3]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
      tbl[4]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100};
      tbl[5]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100};
      tbl[6]  = '{4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0000};
      tbl[7]  = '{4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0000};
      tbl[8]  = '{4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0000};
      tbl[9]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100};
      tbl[10] = '{4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100};
      tbl[11] = '{4'b1100, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000};
      tbl[12] = '{4'b1000, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000};
      tbl[13] = '{4'b0001, 1'b0, 1'b1, 2'd3, 1'b0, 4'b1000};
      tbl[14] = '{4'b1001, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000};
      tbl[15] = '{4'b1001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001};

      #1;
      do_reset();
      set_words(8'h11);
      for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'(8'h11 * (i + 1));
      for (int r = 0; r < 16; r++) begin
         req_valid = tbl[r].valid;
         fifo_full = tbl[r].full;
         sample();
         check($sformatf("tbl%0d_busy", r), busy, tbl[r].busy);
         check($sformatf("tbl%0d_grant_id", r), grant_id, tbl[r].gid);
         check($sformatf("tbl%0d_fifo_wr", r), fifo_wr, tbl[r].wr);
         check($sformatf("tbl%0d_req_ready", r), req_ready, tbl[r].ready);
         if (tbl[r].busy) check($sformatf("tbl%0d_data", r), fifo_data_in, 8'h11 * (tbl[r].gid + 1));
         advance();
      end

      // Burst limit: P0 and P1 alternate in bursts of MAX_BURST with one idle cycle between.
      do_reset();
      set_words(8'hA0);
      req_valid = 4'b0011;
      clog.delete();
      for (int c = 0; c < 15; c++) step();
      check("burst_cycles", clog.size(), 15);
      for (int c = 0; c < 15 && c < clog.size(); c++)
         check($sformatf("burst_c%0d", c), clog[c], (c % 5 == 0) ? -1 : 8'hA0 + (c / 5) % 2);

      // Fairness: four producers valid for 40 cycles.
      do_reset();
      set_words(8'hA0);
      req_valid = 4'b1111;
      wlog.delete();
      for (int c = 0; c < 40; c++) step();
      check("fair_words", wlog.size(), 32);
      for (int k = 0; k < 32 && k < wlog.size(); k++)
         check($sformatf("fair_w%0d", k), wlog[k], 8'hA0 + (k / 4) % 4);
      begin
         int cnt[NREQ];
         for (int i = 0; i < NREQ; i++) cnt[i] = 0;
         foreach (wlog[k]) if (wlog[k] >= 8'hA0 && wlog[k] < 8'hA0 + NREQ) cnt[wlog[k] - 8'hA0]++;
         for (int i = 0; i < NREQ; i++) check($sformatf("fair_cnt_p%0d", i), cnt[i], 8);
      end

      // Async reset while P2 is mid-burst.
      do_reset();
      set_words(8'hA0);
      req_valid = 4'b0100;
      step();
      step();
      #1;
      check("arst_pre_wr", fifo_wr, 1'b1);
      check("arst_pre_gid", grant_id, 2'd2);
      reset = 1'b1;
      model_reset();
      #1;
      check("arst_fifo_wr", fifo_wr, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_req_ready", req_ready, '0);
      step();
      step();
      reset     = 1'b0;
      req_valid = 4'b1111;
      step();
      check("arst_restart_busy", busy, 1'b1);
      check("arst_restart_gid", grant_id, 2'd0);

      // Randomized traffic with back-pressure and occasional resets.
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NREQ; i++) req_valid[i] = ($urandom_range(0, 9) < 7);
         fifo_full = ($urandom_range(0, 3) == 0);
         req_data  = {$urandom};
         reset     = ($urandom_range(0, 99) == 0);
         if (reset) model_reset();
         step();
      end
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
